// File: rtl/neuron_layer_scheduler_if.sv
// Control/data bundle between the layer-level top (master) and the neuron
// scheduler (slave) that sequences the shared MAC datapath.
interface neuron_layer_scheduler_if #(
  parameter int EW = 6,
  parameter int NW = 2
);
  logic          start;
  logic [20:0]   acc_in;
  logic          busy;
  logic          ready;
  logic [NW-1:0] neuron_sel;
  logic [EW-1:0] elem_sel;
  logic          init_acc;
  logic          ld_acc;
  logic          res_we;
  logic [NW-1:0] res_addr;
  logic [20:0]   res_data;

  modport master (
    output start, acc_in,
    input  busy, ready, neuron_sel, elem_sel, init_acc, ld_acc,
           res_we, res_addr, res_data
  );

  modport slave (
    input  start, acc_in,
    output busy, ready, neuron_sel, elem_sel, init_acc, ld_acc,
           res_we, res_addr, res_data
  );
endinterface

// File: rtl/neuron_layer_scheduler.sv
// Time-shares one bias + dot-product MAC across M neurons and stores scaled results.
// Define RELU_EN to clamp negative results to zero when they are stored.
//
// state | meaning
// IDLE  | waiting for start, all outputs low
// INIT  | load bias / clear accumulator for current neuron
// MAC   | accumulate element elem of current neuron (N cycles)
// STORE | write scaled accumulator to result slot of current neuron
// DONE  | one-cycle ready pulse, then back to IDLE
module neuron_layer_scheduler #(
  parameter int N     = 62,
  parameter int M     = 4,
  parameter int EW    = 6,
  parameter int NW    = 2,
  parameter int SHIFT = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  neuron_layer_scheduler_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, INIT, MAC, STORE, DONE} state_t;

  localparam logic [EW-1:0] ELEM_LAST   = EW'(N - 1);
  localparam logic [NW-1:0] NEURON_LAST = NW'(M - 1);

  state_t        state, stateNext;
  logic [EW-1:0] elem, elemNext;
  logic [NW-1:0] neuron, neuronNext;
  logic [19:0]   magScaled;
  logic [20:0]   storeData;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      elem   <= '0;
      neuron <= '0;
    end else begin
      state  <= stateNext;
      elem   <= elemNext;
      neuron <= neuronNext;
    end
  end

  // Element counter only advances inside MAC and is cleared everywhere else.
  always_comb begin
    stateNext  = state;
    elemNext   = '0;
    neuronNext = neuron;
    case (state)
      IDLE: begin
        neuronNext = '0;
        if (bus.start) stateNext = INIT;
      end
      INIT: stateNext = MAC;
      MAC: begin
        if (elem == ELEM_LAST) stateNext = STORE;
        else                   elemNext  = elem + 1'b1;
      end
      STORE: begin
        if (neuron == NEURON_LAST) begin
          stateNext  = DONE;
          neuronNext = '0;
        end else begin
          stateNext  = INIT;
          neuronNext = neuron + 1'b1;
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  assign magScaled = bus.acc_in[19:0] >> SHIFT;

`ifdef RELU_EN
  // Any set sign bit (including negative zero) stores zero.
  assign storeData = bus.acc_in[20] ? 21'd0 : {1'b0, magScaled};
`else
  assign storeData = {bus.acc_in[20], magScaled};
`endif

  always_comb begin
    bus.busy       = 1'b0;
    bus.ready      = 1'b0;
    bus.init_acc   = 1'b0;
    bus.ld_acc     = 1'b0;
    bus.res_we     = 1'b0;
    bus.neuron_sel = '0;
    bus.elem_sel   = '0;
    bus.res_addr   = '0;
    bus.res_data   = '0;
    case (state)
      INIT: begin
        bus.busy       = 1'b1;
        bus.init_acc   = 1'b1;
        bus.neuron_sel = neuron;
      end
      MAC: begin
        bus.busy       = 1'b1;
        bus.ld_acc     = 1'b1;
        bus.neuron_sel = neuron;
        bus.elem_sel   = elem;
      end
      STORE: begin
        bus.busy     = 1'b1;
        bus.res_we   = 1'b1;
        bus.res_addr = neuron;
        bus.res_data = storeData;
      end
      DONE:    bus.ready = 1'b1;
      default: ;
    endcase
  end

endmodule
